// File: rtl/mult_pkg.sv
// Shared types and constants for the add-shift multiplier controller.
package mult_pkg;
    localparam int N_BITS_DEFAULT = 8;
    localparam int STEP_W         = $clog2(N_BITS_DEFAULT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_t;
endpackage

// File: rtl/mult_step_counter.sv
// Step counter for the multiplier sequencer: clears on start, increments per
// completed add/shift pair, saturates at the last step.
module mult_step_counter
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT,
    parameter int W      = $clog2(N_BITS)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);
    localparam logic [W-1:0] LAST = W'(N_BITS - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i && !last_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST);
endmodule

// File: rtl/multiplier_control_unit.sv
// Sequencer for the signed add-shift multiplier. Define MULT_AUTO_CLEAR_EN to
// route every start through CLR so X/A are zeroed before each multiplication.
module multiplier_control_unit
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clear_XA,
    output logic Add,
    output logic Subtract_Enable,
    output logic Shift,
    output logic Busy,
    output logic Done
);
    localparam int W = $clog2(N_BITS);

    mult_state_t  state_q, state_d;
    logic [W-1:0] cnt;
    logic         last_step;
    logic         cnt_clear, cnt_inc;

    assign cnt_clear = (state_q == IDLE) && Run;
    assign cnt_inc   = (state_q == SHIFT);

    mult_step_counter #(.N_BITS(N_BITS), .W(W)) u_cnt (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .cnt_o   (cnt),
        .last_o  (last_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Run) begin
`ifdef MULT_AUTO_CLEAR_EN
                    state_d = CLR;
`else
                    state_d = ADD;
`endif
                end
            end
            CLR:   state_d = ADD;
            ADD:   state_d = SHIFT;
            SHIFT: state_d = last_step ? HOLD : ADD;
            HOLD:  if (!Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Reset gates Clr_Ld so no load is requested while the datapath is being reset.
    assign Clr_Ld = (state_q == IDLE) && ClearA_LoadB && !Run && !Reset;
`ifdef MULT_AUTO_CLEAR_EN
    assign Clear_XA = (state_q == CLR);
`else
    assign Clear_XA = 1'b0;
`endif
    assign Add             = (state_q == ADD) && M;
    assign Subtract_Enable = (state_q == ADD) && M && last_step;
    assign Shift           = (state_q == SHIFT);
    assign Busy            = (state_q == CLR) || (state_q == ADD) || (state_q == SHIFT);
    assign Done            = (state_q == HOLD);

    logic unused_cnt;
    assign unused_cnt = ^cnt;
endmodule

// File: tb/tb_multiplier_control_unit.sv
// Scoreboard bench for multiplier_control_unit with an attached X/A/B datapath
// model; honours MULT_AUTO_CLEAR_EN for latency and Clear_XA expectations.
module tb_multiplier_control_unit;
`ifdef MULT_AUTO_CLEAR_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Clr_Ld, Clear_XA, Add, Subtract_Enable, Shift, Busy, Done;

    multiplier_control_unit #(.N_BITS(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clr_Ld(Clr_Ld), .Clear_XA(Clear_XA), .Add(Add),
        .Subtract_Enable(Subtract_Enable), .Shift(Shift), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Datapath model: 9-bit adder/subtractor plus X/A/B shift registers.
    logic [7:0] S, A, B;
    logic       X;
    logic [8:0] sum;
    assign sum = {A[7], A} + (Subtract_Enable ? (~{S[7], S} + 9'd1) : {S[7], S});
    assign M   = B[0];

    initial begin X = 1'b0; A = 8'h00; B = 8'h00; end

    always @(posedge Clk) begin
        if (Clr_Ld) begin
            X <= 1'b0; A <= 8'h00; B <= S;
        end else if (Clear_XA) begin
            X <= 1'b0; A <= 8'h00;
        end else if (Add) begin
            X <= sum[8]; A <= sum[7:0];
        end else if (Shift) begin
            A <= {X, A[7:1]}; B <= {A[0], B[7:1]};
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int adds;
        int shifts;
        int subs;
        int clrs;
        int busy_len;
        int done_len;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: pops on Busy rise, compares the result on Done rise.
    exp_t cur;
    logic in_run = 1'b0, in_hold = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
    int   busy_len, adds, shifts, subs, clrs, done_len;

    always @(negedge Clk) begin
        if (Reset) begin
            in_run = 1'b0; in_hold = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
        end else begin
            chk("excl_ctrl", 32'(({3'b0, Clr_Ld} + Clear_XA + Add + Shift) > 1
                              || (Subtract_Enable && !Add) || (Clr_Ld && Busy)), 0);
            if (Busy && !prev_busy) begin
                chk("start_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    in_run = 1'b1;
                    busy_len = 0; adds = 0; shifts = 0; subs = 0; clrs = 0;
                end
            end
            if (in_run && Busy) begin
                busy_len++; adds += int'(Add); shifts += int'(Shift);
                subs += int'(Subtract_Enable); clrs += int'(Clear_XA);
            end
            if (Done && !prev_done) begin
                chk("done_in_run", 32'(in_run), 1);
                if (in_run) begin
                    chk("prod_hi", 32'(A), 32'(cur.a));
                    chk("prod_lo", 32'(B), 32'(cur.b));
                    chk("n_add", 32'(adds), 32'(cur.adds));
                    chk("n_shift", 32'(shifts), 32'(cur.shifts));
                    chk("n_sub", 32'(subs), 32'(cur.subs));
                    chk("n_clear_xa", 32'(clrs), 32'(cur.clrs));
                    chk("busy_len", 32'(busy_len), 32'(cur.busy_len));
                    in_run = 1'b0; in_hold = 1'b1; done_len = 0;
                end
            end
            if (in_hold) begin
                if (Done) done_len++;
                else begin
                    chk("done_len", 32'(done_len), 32'(cur.done_len));
                    in_hold = 1'b0;
                end
            end
            prev_busy = Busy; prev_done = Done;
        end
    end

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b, input int adds,
                                input int subs, input int done_len);
        exp_t e;
        e.a = a; e.b = b; e.adds = adds; e.shifts = 8; e.subs = subs;
        e.clrs = LAT - 17; e.busy_len = LAT - 1; e.done_len = done_len;
        return e;
    endfunction

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            if (!Busy && !Done) break;
            @(negedge Clk);
        end
        if (k == 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic load_b(input logic [7:0] s);
        S = s; ClearA_LoadB = 1'b1;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        @(negedge Clk);
    endtask

    task automatic run_op(input logic [7:0] s, input int hold, input exp_t e);
        sb_q.push_back(e);
        S = s; Run = 1'b1;
        repeat (hold) @(negedge Clk);
        Run = 1'b0;
        wait_idle();
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b1; S = 8'h03;
        repeat (3) @(negedge Clk);
        chk("reset_outs", 32'({Clr_Ld, Clear_XA, Add, Subtract_Enable, Shift, Busy, Done}), 0);
        Reset = 1'b0;
        #1;
        chk("idle_clr_ld", 32'(Clr_Ld), 1);
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        @(negedge Clk);

        // 7 * 3 = 21
        run_op(8'h07, 1, mk(8'h00, 8'h15, 2, 0, 1));
        // 7 * -3 = -21, subtract on last step
        load_b(8'hFD);
        run_op(8'h07, 3, mk(8'hFF, 8'hEB, 7, 1, 1));
        // -1 * -127 = 127
        load_b(8'h81);
        run_op(8'hFF, 2, mk(8'h00, 8'h7F, 2, 1, 1));
        // Run held 40 cycles: one operation, Done until Run drops
        load_b(8'h03);
        run_op(8'h07, 40, mk(8'h00, 8'h15, 2, 0, 41 - LAT));
        chk("idle_after_hold", 32'({Busy, Done}), 0);

        // Run wins over ClearA_LoadB; ClearA_LoadB ignored while busy. 5 * -6 = -30
        load_b(8'h05);
        sb_q.push_back(mk(8'hFF, 8'hE2, 2, 0, 1));
        S = 8'hFA; Run = 1'b1; ClearA_LoadB = 1'b1;
        #1;
        chk("run_prio_clr_ld", 32'(Clr_Ld), 0);
        @(negedge Clk);
        Run = 1'b0;
        repeat (5) @(negedge Clk);
        ClearA_LoadB = 1'b0;
        wait_idle();
        @(negedge Clk);

        // Reset during SHIFT at cnt=4, then a full rerun
        load_b(8'h03);
        sb_q.push_back(mk(8'h00, 8'h15, 2, 0, 1));
        S = 8'h07; Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        repeat (LAT - 8) @(negedge Clk);
        chk("mid_shift", 32'({Shift, Busy}), 32'b11);
        Reset = 1'b1;
        #1;
        chk("mid_reset_outs", 32'({Clr_Ld, Clear_XA, Add, Subtract_Enable, Shift, Busy, Done}), 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("post_reset_idle", 32'({Busy, Done}), 0);
        @(negedge Clk);
        load_b(8'h03);
        run_op(8'h07, 1, mk(8'h00, 8'h15, 2, 0, 1));

        // Back-to-back Runs without reload: 3*2 = 6, then 6*2 = 12
        load_b(8'h03);
        run_op(8'h02, 1, mk(8'h00, 8'h06, 2, 0, 1));
        run_op(8'h02, 1, mk(8'h00, 8'h0C, 2, 0, 1));

        repeat (3) @(negedge Clk);
        chk("sb_drained", 32'(sb_q.size()), 0);
        chk("no_open_run", 32'({in_run, in_hold}), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
